// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - four-digit multiplexed seven-segment driver for the Mastermind board
//
// Purpose:
//   Time-multiplexes the round count, both scores and the entered code onto
//   a common-anode four-digit display. The first cycle of every digit slot
//   is blanked. An optional blinking entry cursor is available. All outputs
//   are registered, so an input change shows up on the next cycle.
//
// Parameters:
//   REFRESH_DIV  cycles per digit slot, including the blank cycle (>= 2)
//   BLINK_DIV    full scans per cursor blink phase (>= 1)
//
// Build option:
//   SSD_CURSOR_BLINK_EN  when defined, the cursor alternates between dash
//                        and blank every BLINK_DIV scans; otherwise the
//                        cursor is a steady dash and no blink logic exists.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   mode[1:0]    in   0 score, 1 code, 2 all dashes, 3 blank
//   round_count  in   round number, shown as 0-3
//   scoreA       in   player A score (leftmost digit)
//   scoreB       in   player B score (rightmost digit)
//   code_digits  in   four 3-bit letters, first-entered letter in [11:9]
//   entry_count  in   letters entered so far, values above 4 act as 4
//   an[3:0]      out  digit enables, active-low, an[3] is leftmost
//   seg[6:0]     out  segments {g,f,e,d,c,b,a}, active-low

module ssd_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [1:0]  round_count,
  input  logic [1:0]  scoreA,
  input  logic [1:0]  scoreB,
  input  logic [11:0] code_digits,
  input  logic [2:0]  entry_count,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] MODE_SCORE = 2'd0;
  localparam logic [1:0] MODE_CODE  = 2'd1;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  function automatic logic [6:0] num_glyph(input logic [1:0] v);
    case (v)
      2'd0:    num_glyph = 7'b1000000;
      2'd1:    num_glyph = 7'b1111001;
      2'd2:    num_glyph = 7'b0100100;
      default: num_glyph = 7'b0110000;
    endcase
  endfunction

  function automatic logic [6:0] letter_glyph(input logic [2:0] v);
    case (v)
      3'd0:    letter_glyph = 7'b0001001; // H
      3'd1:    letter_glyph = 7'b0001000; // A
      3'd2:    letter_glyph = 7'b1000110; // C
      3'd3:    letter_glyph = 7'b0000110; // E
      3'd4:    letter_glyph = 7'b0001110; // F
      3'd5:    letter_glyph = 7'b1000111; // L
      3'd6:    letter_glyph = 7'b0001100; // P
      default: letter_glyph = 7'b1000001; // U
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       cnt_wrap;
  logic       scan_wrap;
  logic [1:0] pos;
  logic [2:0] ec_sat;
  logic [2:0] letter;
  logic [6:0] cursor_glyph;
  logic [6:0] glyph;

  assign cnt_wrap  = (cnt_q == CNT_MAX);
  assign scan_wrap = cnt_wrap && (sel_q == 2'd3);

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    sel_d = cnt_wrap ? sel_q + 2'd1 : sel_q;
  end

`ifdef SSD_CURSOR_BLINK_EN
  localparam int unsigned SCAN_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              phase_q, phase_d;

  always_comb begin
    scan_d  = scan_q;
    phase_d = phase_q;
    if (scan_wrap) begin
      if (scan_q == SCAN_MAX) begin
        scan_d  = '0;
        phase_d = ~phase_q;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      phase_q <= phase_d;
    end
  end

  // Blank phase keeps the digit enabled but with no segments lit.
  assign cursor_glyph = phase_q ? SEG_BLANK : SEG_DASH;
`else
  logic unused_blink;
  assign unused_blink = ^{scan_wrap, BLINK_DIV[0]};
  assign cursor_glyph = SEG_DASH;
`endif

  // Position counted from the left: sel 3 is the leftmost digit.
  assign pos    = ~sel_q;
  assign ec_sat = entry_count[2] ? 3'd4 : entry_count;

  always_comb begin
    case (pos)
      2'd0:    letter = code_digits[11:9];
      2'd1:    letter = code_digits[8:6];
      2'd2:    letter = code_digits[5:3];
      default: letter = code_digits[2:0];
    endcase
  end

  always_comb begin
    glyph = SEG_DASH;
    case (mode)
      MODE_SCORE: begin
        case (sel_q)
          2'd3:    glyph = num_glyph(scoreA);
          2'd2:    glyph = SEG_DASH;
          2'd1:    glyph = num_glyph(round_count);
          default: glyph = num_glyph(scoreB);
        endcase
      end
      MODE_CODE: begin
        if ({1'b0, pos} < ec_sat) begin
          glyph = letter_glyph(letter);
        end else if ({1'b0, pos} == ec_sat) begin
          glyph = cursor_glyph;
        end else begin
          glyph = SEG_DASH;
        end
      end
      default: glyph = SEG_DASH;
    endcase
  end

  always_comb begin
    if ((cnt_q == '0) || (mode == MODE_BLANK)) begin
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(4'b0001 << sel_q);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - scoreboard bench for ssd_scan_driver with a time-based display model

module tb_ssd_scan_driver;

  localparam int R = 4;
  localparam int B = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [1:0]  round_count;
  logic [1:0]  scoreA;
  logic [1:0]  scoreB;
  logic [11:0] code_digits;
  logic [2:0]  entry_count;
  logic [3:0]  an;
  logic [6:0]  seg;

  ssd_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset), .mode(mode), .round_count(round_count),
    .scoreA(scoreA), .scoreB(scoreB), .code_digits(code_digits),
    .entry_count(entry_count), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] letter_tab [8];
  logic [6:0] num_tab [4];
  initial begin
    letter_tab[0] = 7'b0001001; letter_tab[1] = 7'b0001000;
    letter_tab[2] = 7'b1000110; letter_tab[3] = 7'b0000110;
    letter_tab[4] = 7'b0001110; letter_tab[5] = 7'b1000111;
    letter_tab[6] = 7'b0001100; letter_tab[7] = 7'b1000001;
    num_tab[0] = 7'b1000000; num_tab[1] = 7'b1111001;
    num_tab[2] = 7'b0100100; num_tab[3] = 7'b0110000;
  end

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  int unsigned k;          // clock edges since the last reset edge
  logic [10:0] exp_q [$];
  int unsigned tag_q [$];
  int vectors;
  int miscompares;

  // Display content as a function of elapsed time and current inputs.
  function automatic logic [10:0] model();
    int cnt, sel, scans, p, ec;
    bit phase;
    logic [6:0] g;
    logic [3:0] a;
    logic [2:0] lt;
    if (reset) return {4'b1111, BLANK};
    cnt   = int'(k % R);
    sel   = int'((k / R) % 4);
    scans = int'(k / (4 * R));
    phase = ((scans / B) % 2) == 1;
    if (cnt == 0 || mode == 2'd3) return {4'b1111, BLANK};
    a = 4'b1111;
    a[sel] = 1'b0;
    g = DASH;
    if (mode == 2'd0) begin
      if (sel == 3) g = num_tab[scoreA];
      else if (sel == 1) g = num_tab[round_count];
      else if (sel == 0) g = num_tab[scoreB];
    end else if (mode == 2'd1) begin
      p  = 3 - sel;
      ec = (entry_count > 3'd4) ? 4 : int'(entry_count);
      lt = 3'((code_digits >> (9 - 3 * p)) & 12'h7);
      if (p < ec) g = letter_tab[lt];
      else if (p == ec) begin
`ifdef SSD_CURSOR_BLINK_EN
        g = phase ? BLANK : DASH;
`else
        g = DASH;
`endif
      end
    end
    return {a, g};
  endfunction

  // Push the expectation for the coming edge, then wait for it.
  task automatic cycle();
    exp_q.push_back(model());
    tag_q.push_back(k);
    if (reset) k = 0;
    else k = k + 1;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    round_count = 2'($urandom_range(0, 3));
    scoreA      = 2'($urandom_range(0, 3));
    scoreB      = 2'($urandom_range(0, 3));
    code_digits = 12'($urandom);
    entry_count = 3'($urandom_range(0, 7));
  endtask

  // Monitor: compares every registered output against the queued expectation.
  always @(posedge clk) begin
    logic [10:0] e;
    int unsigned t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      if ({an, seg} !== e) begin
        miscompares++;
        $display("FAIL display k=%0d mode=%0d ec=%0d: got an=%b seg=%b, want an=%b seg=%b",
                 t, mode, entry_count, an, seg, e[10:7], e[6:0]);
      end
    end
  end

  initial begin
    bit mid_reset_done;
    int seg_len;
    vectors = 0;
    miscompares = 0;
    k = 0;
    mid_reset_done = 0;
    reset = 1'b1;
    mode = 2'd0;
    round_count = 2'd1;
    scoreA = 2'd2;
    scoreB = 2'd3;
    code_digits = 12'b100_001_010_011;
    entry_count = 3'd4;
    @(negedge clk);

    repeat (3) cycle();
    reset = 1'b0;

    // Score view, two full scans.
    repeat (2 * 4 * R) cycle();

    // Code view, all four letters, then saturated entry counts.
    mode = 2'd1;
    repeat (4 * R) cycle();
    entry_count = 3'd6;
    repeat (4 * R) cycle();

    // Cursor on the third digit across several blink phases.
    entry_count = 3'd2;
    repeat (6 * 4 * R) cycle();

    // Reset asserted at sel=2, cnt=3.
    while ((k % (4 * R)) != 11) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (4 * R) cycle();

    // Blank mode for a scan, then dashes mid-scan.
    mode = 2'd3;
    repeat (4 * R + 2) cycle();
    mode = 2'd2;
    repeat (4 * R) cycle();

    // Randomized segments with occasional mid-run resets.
    repeat (150) begin
      mode = 2'($urandom_range(0, 3));
      rand_inputs();
      seg_len = $urandom_range(1, 40);
      repeat (seg_len) begin
        if ($urandom_range(0, 9) == 0) rand_inputs();
        reset = ($urandom_range(0, 199) == 0);
        if (!mid_reset_done && k > 0 && (k % (4 * R)) == 11 && mode == 2'd1) begin
          reset = 1'b1;
          mid_reset_done = 1;
        end
        cycle();
      end
    end
    reset = 1'b0;

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
